// File: rtl/cache_types.sv
// Shared types for the cache-level arbiter: bus widths and FSM/requester enums.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } arb_req_t;

endpackage

// File: rtl/cache_level_split_register.sv
// Registered downstream request stage: captures address/wdata/strobes toward L2 on load.
// Latency: 1 cycle from load to outputs.
// Backpressure: none; holds its contents whenever load is low.
// Ports:
//   clk, rst_n                      clock, async active-low reset (clears everything)
//   load                            capture the req_* inputs at the next rising edge
//   req_address/wdata/read/write    values to capture
//   l2_address/wdata/read/write     registered request presented to L2
module cache_level_split_register
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [15:0]  req_address,
  input  logic [127:0] req_wdata,
  input  logic         req_read,
  input  logic         req_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic         l2_read,
  output logic         l2_write
);

  lc3b_word  address_q, address_d;
  cache_line wdata_q, wdata_d;
  logic      read_q, read_d;
  logic      write_q, write_d;

  always_comb begin
    address_d = address_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    if (load) begin
      address_d = req_address;
      wdata_d   = req_wdata;
      read_d    = req_read;
      write_d   = req_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      address_q <= address_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
    end
  end

  assign l2_address = address_q;
  assign l2_wdata   = wdata_q;
  assign l2_read    = read_q;
  assign l2_write   = write_q;

endmodule

// File: rtl/cache_level_arbiter.sv
// Fair arbiter giving split I-cache / D-cache miss and writeback traffic one shared L2 port.
// Latency: request in IDLE reaches the L2 strobes next cycle; resp is routed back combinationally.
// Backpressure: the loser is held off until the winner's L2 transaction completes plus one IDLE cycle.
// Ports:
//   clk, rst_n                                     clock, async active-low reset
//   icache_/dcache_ address, wdata, read, write    requests from each L1 (held until resp)
//   icache_/dcache_ resp, rdata                    completion and returned line per L1
//   l2_address, l2_wdata, l2_read, l2_write        registered request to L2
//   l2_resp, l2_rdata                              completion and line from L2
//   busy                                           high whenever a grant is outstanding
module cache_level_arbiter
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  icache_address,
  input  logic [127:0] icache_wdata,
  input  logic         icache_read,
  input  logic         icache_write,
  output logic         icache_resp,
  output logic [127:0] icache_rdata,
  input  logic [15:0]  dcache_address,
  input  logic [127:0] dcache_wdata,
  input  logic         dcache_read,
  input  logic         dcache_write,
  output logic         dcache_resp,
  output logic [127:0] dcache_rdata,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic         l2_read,
  output logic         l2_write,
  input  logic         l2_resp,
  input  logic [127:0] l2_rdata,
  output logic         busy
);

  arb_state_t state_q, state_d;
  arb_req_t   last_grant_q, last_grant_d;

  logic      i_req, d_req;
  logic      ld;
  lc3b_word  ld_address;
  cache_line ld_wdata;
  logic      ld_read, ld_write;

  assign i_req = icache_read | icache_write;
  assign d_req = dcache_read | dcache_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ld           = 1'b0;
    // Completion reloads the current address/wdata so only the strobes drop.
    ld_address   = l2_address;
    ld_wdata     = l2_wdata;
    ld_read      = 1'b0;
    ld_write     = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester served least recently wins.
        if (i_req && (!d_req || last_grant_q == REQ_D)) begin
          state_d    = SERVE_I;
          ld         = 1'b1;
          ld_address = icache_address;
          ld_wdata   = icache_wdata;
          ld_read    = icache_read;
          ld_write   = icache_write;
        end else if (d_req) begin
          state_d    = SERVE_D;
          ld         = 1'b1;
          ld_address = dcache_address;
          ld_wdata   = dcache_wdata;
          ld_read    = dcache_read;
          ld_write   = dcache_write;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_d      = IDLE;
          last_grant_d = REQ_I;
          ld           = 1'b1;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_d      = IDLE;
          last_grant_d = REQ_D;
          ld           = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  cache_level_split_register u_split (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ld),
    .req_address (ld_address),
    .req_wdata   (ld_wdata),
    .req_read    (ld_read),
    .req_write   (ld_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_read     (l2_read),
    .l2_write    (l2_write)
  );

  // Responses are gated by state so a stray l2_resp in IDLE never reaches a cache.
  assign icache_resp  = (state_q == SERVE_I) & l2_resp;
  assign dcache_resp  = (state_q == SERVE_D) & l2_resp;
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cache_level_arbiter.sv
// Self-checking bench for cache_level_arbiter: directed vector table, corner sequences,
// and randomized two-cache traffic against a transaction-level scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cache_level_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  icache_address, dcache_address, l2_address;
  logic [127:0] icache_wdata, dcache_wdata, l2_wdata;
  logic         icache_read, icache_write, dcache_read, dcache_write;
  logic         icache_resp, dcache_resp;
  logic [127:0] icache_rdata, dcache_rdata, l2_rdata;
  logic         l2_read, l2_write, l2_resp, busy;

  always #5 clk = ~clk;

  cache_level_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_address (icache_address),
    .icache_wdata   (icache_wdata),
    .icache_read    (icache_read),
    .icache_write   (icache_write),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_resp    (dcache_resp),
    .dcache_rdata   (dcache_rdata),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_resp        (l2_resp),
    .l2_rdata       (l2_rdata),
    .busy           (busy)
  );

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] W1 = {8{16'h1111}};
  localparam logic [127:0] W2 = {8{16'h2222}};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_address = '0; icache_wdata = '0; icache_read = 1'b0; icache_write = 1'b0;
    dcache_address = '0; dcache_wdata = '0; dcache_read = 1'b0; dcache_write = 1'b0;
    l2_resp = 1'b0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One row = inputs driven during a cycle and outputs required in that same cycle.
  typedef struct {
    logic ir, iw, dr, dw, rsp;
    logic e_ir, e_dr, e_rd, e_wr, e_busy;
    logic [15:0]  e_a;
    logic [127:0] e_wd;
  } vec_t;

  function automatic vec_t mk(input logic ir, iw, dr, dw, rsp,
                              input logic e_ir, e_dr, e_rd, e_wr, e_busy,
                              input logic [15:0] e_a, input logic [127:0] e_wd);
    vec_t v;
    v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.rsp = rsp;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_rd = e_rd; v.e_wr = e_wr; v.e_busy = e_busy;
    v.e_a = e_a; v.e_wd = e_wd;
    return v;
  endfunction

  typedef struct packed {
    logic [15:0]  a;
    logic [127:0] wd;
    logic         rd;
    logic         wr;
  } txn_t;

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    t.a  = 16'($urandom);
    t.wd = {$urandom, $urandom, $urandom, $urandom};
    k    = $urandom_range(1, 3);
    t.rd = k[0];
    t.wr = k[1];
    return t;
  endfunction

  vec_t tv [12];

  // Scoreboard state for the random phase (0 = I-cache, 1 = D-cache).
  txn_t qi[$];
  txn_t qd[$];
  int   gap[2];
  bit   active, start_next, pi, pd;
  int   owner, win, last, cnt;
  txn_t head;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // ---------------- directed vector table ----------------
    //            ir iw dr dw rsp  eI eD rd wr busy  addr      wdata
    tv[0]  = mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0,   16'h0000, '0);
    tv[1]  = mk(1, 0, 0, 0, 0,   0, 0, 1, 0, 1,   16'h1230, W2);
    tv[2]  = mk(1, 0, 0, 0, 0,   0, 0, 1, 0, 1,   16'h1230, W2);
    tv[3]  = mk(1, 0, 0, 0, 1,   1, 0, 1, 0, 1,   16'h1230, W2);
    tv[4]  = mk(1, 0, 0, 1, 0,   0, 0, 0, 0, 0,   16'h1230, W2);
    tv[5]  = mk(1, 0, 0, 1, 0,   0, 0, 0, 1, 1,   16'h4000, W1);
    tv[6]  = mk(1, 0, 0, 1, 1,   0, 1, 0, 1, 1,   16'h4000, W1);
    tv[7]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0,   16'h4000, W1);
    tv[8]  = mk(1, 0, 0, 0, 0,   0, 0, 1, 0, 1,   16'h1230, W2);
    tv[9]  = mk(1, 0, 0, 0, 1,   1, 0, 1, 0, 1,   16'h1230, W2);
    tv[10] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   16'h1230, W2);
    tv[11] = mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 0,   16'h1230, W2);

    icache_address = 16'h1230; icache_wdata = W2;
    dcache_address = 16'h4000; dcache_wdata = W1;
    l2_rdata = A5;
    for (int i = 0; i < 12; i++) begin
      icache_read = tv[i].ir; icache_write = tv[i].iw;
      dcache_read = tv[i].dr; dcache_write = tv[i].dw;
      l2_resp = tv[i].rsp;
      @(negedge clk);
      chk1($sformatf("tv%0d_icache_resp", i), icache_resp, tv[i].e_ir);
      chk1($sformatf("tv%0d_dcache_resp", i), dcache_resp, tv[i].e_dr);
      chk1($sformatf("tv%0d_l2_read", i), l2_read, tv[i].e_rd);
      chk1($sformatf("tv%0d_l2_write", i), l2_write, tv[i].e_wr);
      chk1($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tv%0d_l2_address", i), 128'(l2_address), 128'(tv[i].e_a));
      chk($sformatf("tv%0d_l2_wdata", i), l2_wdata, tv[i].e_wd);
      chk($sformatf("tv%0d_icache_rdata", i), icache_rdata, A5);
      chk($sformatf("tv%0d_dcache_rdata", i), dcache_rdata, A5);
      next_cycle();
    end

    // ---------------- first tie after reset: I wins, D follows at k+2 ----------------
    do_reset();
    icache_address = 16'h1230; dcache_address = 16'h5000;
    icache_read = 1'b1; dcache_read = 1'b1;
    @(negedge clk); chk1("tie_c0_busy", busy, 1'b0); next_cycle();
    @(negedge clk);
    chk1("tie_c1_l2_read", l2_read, 1'b1);
    chk("tie_c1_addr", 128'(l2_address), 128'(16'h1230));
    next_cycle();
    l2_resp = 1'b1;
    @(negedge clk);
    chk1("tie_c2_iresp", icache_resp, 1'b1);
    chk1("tie_c2_dresp", dcache_resp, 1'b0);
    next_cycle();
    icache_read = 1'b0; l2_resp = 1'b0;
    @(negedge clk);
    chk1("tie_c3_l2_read", l2_read, 1'b0);
    chk1("tie_c3_busy", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("tie_c4_l2_read", l2_read, 1'b1);
    chk("tie_c4_addr", 128'(l2_address), 128'(16'h5000));
    next_cycle();
    l2_resp = 1'b1;
    @(negedge clk);
    chk1("tie_c5_dresp", dcache_resp, 1'b1);
    chk1("tie_c5_iresp", icache_resp, 1'b0);
    next_cycle();

    // ---------------- asynchronous reset in the middle of a D writeback ----------------
    do_reset();
    dcache_write = 1'b1; dcache_address = 16'h4000; dcache_wdata = W1;
    @(negedge clk); next_cycle();
    @(negedge clk);
    chk1("rst_pre_l2_write", l2_write, 1'b1);
    chk1("rst_pre_busy", busy, 1'b1);
    next_cycle();
    l2_resp = 1'b1;
    #2;
    chk1("rst_pre_dresp", dcache_resp, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_async_l2_write", l2_write, 1'b0);
    chk1("rst_async_l2_read", l2_read, 1'b0);
    chk1("rst_async_dresp", dcache_resp, 1'b0);
    chk1("rst_async_iresp", icache_resp, 1'b0);
    chk1("rst_async_busy", busy, 1'b0);
    chk("rst_async_addr", 128'(l2_address), 128'(16'h0000));
    chk("rst_async_wdata", l2_wdata, '0);
    l2_resp = 1'b0;
    icache_read = 1'b1; icache_address = 16'h1230;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk); chk1("rst_post_idle_busy", busy, 1'b0); next_cycle();
    @(negedge clk);
    chk1("rst_post_l2_read", l2_read, 1'b1);
    chk1("rst_post_l2_write", l2_write, 1'b0);
    chk("rst_post_addr", 128'(l2_address), 128'(16'h1230));
    next_cycle();

    // ---------------- randomized traffic against the scoreboard ----------------
    do_reset();
    active = 1'b0; start_next = 1'b0; last = 1; owner = 0; win = 0; cnt = 0;
    gap[0] = 0; gap[1] = 0;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      if (start_next) begin
        active = 1'b1; owner = win; cnt = $urandom_range(0, 4); start_next = 1'b0;
      end
      if (cyc < 2400 && qi.size() < 2 && $urandom_range(0, 3) == 0) qi.push_back(rand_txn());
      if (cyc < 2400 && qd.size() < 2 && $urandom_range(0, 3) == 0) qd.push_back(rand_txn());
      pi = (qi.size() > 0) && (gap[0] == 0);
      pd = (qd.size() > 0) && (gap[1] == 0);
      if (pi) begin
        icache_address = qi[0].a; icache_wdata = qi[0].wd;
        icache_read = qi[0].rd; icache_write = qi[0].wr;
      end else begin
        icache_read = 1'b0; icache_write = 1'b0;
      end
      if (pd) begin
        dcache_address = qd[0].a; dcache_wdata = qd[0].wd;
        dcache_read = qd[0].rd; dcache_write = qd[0].wr;
      end else begin
        dcache_read = 1'b0; dcache_write = 1'b0;
      end
      l2_resp  = active && (cnt == 0);
      l2_rdata = {$urandom, $urandom, $urandom, $urandom};

      @(negedge clk);
      head = '0;
      if (active) head = (owner == 0) ? qi[0] : qd[0];
      chk1("rnd_busy", busy, active);
      chk1("rnd_l2_read", l2_read, active && head.rd);
      chk1("rnd_l2_write", l2_write, active && head.wr);
      if (active) begin
        chk("rnd_l2_address", 128'(l2_address), 128'(head.a));
        chk("rnd_l2_wdata", l2_wdata, head.wd);
      end
      chk1("rnd_icache_resp", icache_resp, active && owner == 0 && l2_resp);
      chk1("rnd_dcache_resp", dcache_resp, active && owner == 1 && l2_resp);
      chk("rnd_icache_rdata", icache_rdata, l2_rdata);
      chk("rnd_dcache_rdata", dcache_rdata, l2_rdata);

      if (gap[0] > 0) gap[0]--;
      if (gap[1] > 0) gap[1]--;
      if (!active) begin
        if (pi || pd) begin
          start_next = 1'b1;
          win = (pi && pd) ? (1 - last) : (pi ? 0 : 1);
        end
      end else if (l2_resp) begin
        if (owner == 0) void'(qi.pop_front());
        else            void'(qd.pop_front());
        gap[owner] = $urandom_range(0, 2);
        last   = owner;
        active = 1'b0;
      end else begin
        cnt--;
      end
      next_cycle();
    end
    chk1("rnd_drain_icache_queue", qi.size() == 0, 1'b1);
    chk1("rnd_drain_dcache_queue", qd.size() == 0, 1'b1);
    chk1("rnd_drain_idle", active, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_level_arbiter.md
# cache_level_arbiter

Arbitrates between split I-cache and D-cache miss/writeback traffic for a single shared L2 port. Sits between the L1 caches and the L2 and uses a cache_level_split_register instance as its registered downstream request stage. Grants one requester at a time, fairly, holds the grant until L2 responds, and routes the response and line data back to the winner.

## Interface
Parameters: none. Widths come from lc3b_types and cache_types: lc3b_word is 16 bits, cache_line is 128 bits.

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- icache_address  in  16  I-cache request address (lc3b_word)
- icache_wdata  in  128  I-cache write line (cache_line)
- icache_read  in  1  I-cache read request
- icache_write  in  1  I-cache write request
- icache_resp  out  1  I-cache transaction complete
- icache_rdata  out  128  line returned to I-cache
- dcache_address, dcache_wdata, dcache_read, dcache_write, dcache_resp, dcache_rdata  same as the icache_* ports, for the D-cache
- l2_address  out  16  registered request address to L2
- l2_wdata  out  128  registered write line to L2
- l2_read  out  1  registered L2 read strobe
- l2_write  out  1  registered L2 write strobe
- l2_resp  in  1  L2 transaction complete
- l2_rdata  in  128  L2 read line
- busy  out  1  high in any state except IDLE

## Operation
- A requester is requesting when its read OR its write is high. It holds address, wdata and strobe stable until it sees its resp, then drops the strobe at the next edge.
- FSM states: IDLE, SERVE_I, SERVE_D.
  - IDLE, only I requesting: go to SERVE_I. Only D requesting: go to SERVE_D.
  - IDLE, both requesting: grant the requester that is not last_grant. last_grant resets to D, so I wins the first tie.
  - IDLE, none requesting: stay in IDLE.
  - SERVE_x, l2_resp=1: return to IDLE and set last_grant to x.
  - SERVE_x, l2_resp=0: stay in SERVE_x.
- On the IDLE to SERVE_x edge, the split register loads x's address, wdata, read and write. On the SERVE_x to IDLE edge it loads read=0 and write=0; address and wdata keep their old values.
- A requester asserting both read and write has both forwarded unchanged. This is not checked.
- Response routing is combinational:
  - icache_resp = l2_resp in SERVE_I, 0 otherwise.
  - dcache_resp = l2_resp in SERVE_D, 0 otherwise.
  - Both rdata outputs always equal l2_rdata. The caches use rdata only when their resp is high.
- Reset, including mid-transaction: asynchronously forces
  - state = IDLE, last_grant = D;
  - l2_address = 0, l2_wdata = 0, l2_read = 0, l2_write = 0;
  - icache_resp = 0, dcache_resp = 0, busy = 0.
  - Any in-flight L2 transaction is abandoned; L2 shares the same reset.

## Timing
- Request high in IDLE during cycle 0: state and l2 strobe are valid in cycle 1.
- l2_resp high in cycle k: the granted requester's resp is high in cycle k. State is IDLE and l2 strobes are low in cycle k+1.
- IDLE always lasts at least one cycle after a transaction. This prevents re-granting a stale strobe. The earliest next L2 strobe is cycle k+2.
- With both caches continuously requesting, grants strictly alternate. Each requester waits at most one other transaction.
- A request that arrives while the other requester is being served is held off and granted at the next IDLE.

## Structure
- cache_types holds the shared typedefs and constants:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D};
  - arb_req_t enum {REQ_I, REQ_D}.
- The sub-module is cache_level_split_register, used as the downstream stage. Its load input is driven high on grant and on completion edges.
- The FSM, the last_grant flop and the request mux are in the top module.

## Test plan
- Single I read: icache_read=1 at 0x1230 from cycle 0; L2 asserts resp in cycle 3 with rdata=128'hA5…A5. Required: l2_read=1 and l2_address=0x1230 in cycles 1-3, icache_resp=1 only in cycle 3 with that rdata, l2_read=0 in cycle 4, dcache_resp=0 throughout.
- Simultaneous first tie: both caches request in cycle 0 after reset. Required: I is served first. D gets l2_address/l2_read in the cycle two after I's resp.
- Continuous contention: both caches request for 6 transactions. Required: grant order I, D, I, D, I, D and resp never sent to the non-granted cache.
- D writeback then fill: dcache_write=1 at 0x4000 with wdata=128'h1111…, then dcache_read=1 at 0x5000. Required: l2_write with that wdata first, then l2_read at 0x5000. Any I request arriving meanwhile is granted between the two D transactions.
- Reset mid-transaction: rst_n low while in SERVE_D with l2_write=1. Required: l2_write, l2_read, resps and busy are 0 immediately, without waiting for clk. After release, an I/D tie grants I.
